// File: rtl/v_sync_gen.sv
// Vertical timing stage. Counts lines from the horizontal stage's pixel x and
// produces vsync, the combined video enable, frame markers and a test-pattern
// pixel. Every output comes out of a single register stage, so hsync, vsync, x,
// y and rgb leave on the same cycle and stay mutually aligned.
module v_sync_gen #(
   parameter int unsigned H_TOTAL  = 800,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hsync_in,
   input  logic       h_active_in,
   input  logic [9:0] x_in,
   input  logic [1:0] pattern_sel,
   output logic       hsync,
   output logic       vsync,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       is_vertical_active,
   output logic       video_on,
   output logic       frame_start,
   output logic [7:0] frame_count,
   output logic [7:0] rgb
);

   localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] HLast      = 10'(H_TOTAL - 1);
   localparam logic [9:0] VLast      = 10'(V_TOTAL - 1);
   localparam logic [9:0] VActive    = 10'(V_ACTIVE);
   localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

   // Line/frame state
   logic [9:0] v_cnt_q, v_cnt_d;
   logic [7:0] frame_count_q, frame_count_d;
   logic [1:0] pattern_q, pattern_d;

   // Output register stage
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic [9:0] x_q, x_d;
   logic [9:0] y_q, y_d;
   logic       v_active_q, v_active_d;
   logic       video_on_q, video_on_d;
   logic       frame_start_q, frame_start_d;
   logic [7:0] rgb_q, rgb_d;

   // Decodes on the current inputs and the pre-update line count
   logic line_end;
   logic v_last;
   logic frame_end;
   logic v_active;
   logic in_vsync;
   logic pix_on;
   logic [7:0] pattern_pix;

   // Line/frame decodes; out-of-range x_in simply never produces a line end
   always_comb begin
      line_end  = (x_in == HLast);
      v_last    = (v_cnt_q == VLast);
      frame_end = line_end && v_last;
      v_active  = (v_cnt_q < VActive);
      in_vsync  = (v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd);
      pix_on    = h_active_in && v_active;
   end

   // Line counter, frame counter and pattern latch; pattern only moves at frame end
   always_comb begin
      v_cnt_d       = v_cnt_q;
      frame_count_d = frame_count_q;
      pattern_d     = pattern_q;
      if (line_end) begin
         v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
      end
      if (frame_end) begin
         frame_count_d = frame_count_q + 8'd1;
         pattern_d     = pattern_sel;
      end
   end

   // Test-pattern pixel, selected by the frame-stable pattern register
   always_comb begin
      pattern_pix = 8'h00;
      unique case (pattern_q)
         2'd0: pattern_pix = 8'hFF;
         2'd1: pattern_pix = {x_in[9:7], x_in[9:7], x_in[8:7]};
         2'd2: pattern_pix = (x_in[5] ^ v_cnt_q[5]) ? 8'hFF : 8'h00;
         2'd3: pattern_pix = frame_count_q;
         default: pattern_pix = 8'h00;
      endcase
   end

   // Next values for the aligned output stage, all from pre-update state
   always_comb begin
      hsync_d       = hsync_in;
      x_d           = x_in;
      y_d           = v_cnt_q;
      vsync_d       = ~in_vsync;
      v_active_d    = v_active;
      video_on_d    = pix_on;
      frame_start_d = (x_in == 10'd0) && (v_cnt_q == 10'd0);
      rgb_d         = pix_on ? pattern_pix : 8'h00;
   end

   // State and output registers with synchronous reset taking priority
   always_ff @(posedge clk) begin
      if (reset) begin
         v_cnt_q       <= 10'd0;
         frame_count_q <= 8'd0;
         pattern_q     <= 2'd0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         x_q           <= 10'd0;
         y_q           <= 10'd0;
         v_active_q    <= 1'b0;
         video_on_q    <= 1'b0;
         frame_start_q <= 1'b0;
         rgb_q         <= 8'h00;
      end else begin
         v_cnt_q       <= v_cnt_d;
         frame_count_q <= frame_count_d;
         pattern_q     <= pattern_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         x_q           <= x_d;
         y_q           <= y_d;
         v_active_q    <= v_active_d;
         video_on_q    <= video_on_d;
         frame_start_q <= frame_start_d;
         rgb_q         <= rgb_d;
      end
   end

   assign hsync              = hsync_q;
   assign vsync              = vsync_q;
   assign x                  = x_q;
   assign y                  = y_q;
   assign is_vertical_active = v_active_q;
   assign video_on           = video_on_q;
   assign frame_start        = frame_start_q;
   assign frame_count        = frame_count_q;
   assign rgb                = rgb_q;

endmodule

// File: tb/tb_v_sync_gen.sv
// Directed bench for v_sync_gen. Vertical timing is shrunk (36/2/2/2 -> 42 lines)
// so full frames and a 256-frame wrap fit a short run; line length stays 800.
// Sync lines are therefore 38..39 and the last active line is 35.
module tb_v_sync_gen;

   localparam int unsigned HT = 800;
   localparam int unsigned VA = 36;
   localparam int unsigned VF = 2;
   localparam int unsigned VS = 2;
   localparam int unsigned VB = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic       hsync_in;
   logic       h_active_in;
   logic [9:0] x_in;
   logic [1:0] pattern_sel;
   logic       hsync;
   logic       vsync;
   logic [9:0] x;
   logic [9:0] y;
   logic       is_vertical_active;
   logic       video_on;
   logic       frame_start;
   logic [7:0] frame_count;
   logic [7:0] rgb;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   v_sync_gen #(
      .H_TOTAL (HT),
      .V_ACTIVE(VA),
      .V_FRONT (VF),
      .V_SYNC  (VS),
      .V_BACK  (VB)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .hsync_in          (hsync_in),
      .h_active_in       (h_active_in),
      .x_in              (x_in),
      .pattern_sel       (pattern_sel),
      .hsync             (hsync),
      .vsync             (vsync),
      .x                 (x),
      .y                 (y),
      .is_vertical_active(is_vertical_active),
      .video_on          (video_on),
      .frame_start       (frame_start),
      .frame_count       (frame_count),
      .rgb               (rgb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   // Drive one pixel (hsync low over 656..751, active below 640), clock it, settle
   task automatic tick(input logic [9:0] xi);
      x_in        = xi;
      h_active_in = (xi < 10'd640);
      hsync_in    = !((xi >= 10'd656) && (xi < 10'd752));
      @(posedge clk);
      #1;
   endtask

   // Finish the current compressed line and start the next at x=0, n times
   task automatic next_lines(input int n);
      for (int i = 0; i < n; i++) begin
         tick(10'd799);
         tick(10'd0);
      end
   endtask

   int unsigned err_y, err_x, err_hs, err_vs, err_von, err_va, err_fs, err_rgb;
   int unsigned vs_low, fs_cnt;
   logic        exp_vs, exp_von;
   logic [7:0]  exp_fc;

   initial begin
      reset       = 1'b1;
      pattern_sel = 2'd0;
      x_in        = 10'd0;
      h_active_in = 1'b0;
      hsync_in    = 1'b1;

      // Reset held 3 cycles with x_in moving
      tick(10'd5);
      tick(10'd6);
      tick(10'd7);
      check("rst_hsync", 32'(hsync), 32'd1);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_x", 32'(x), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_vact", 32'(is_vertical_active), 32'd0);
      check("rst_video_on", 32'(video_on), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_rgb", 32'(rgb), 32'd0);
      reset = 1'b0;

      // One full-length frame, checked on every cycle
      err_y = 0; err_x = 0; err_hs = 0; err_vs = 0; err_von = 0; err_va = 0;
      err_fs = 0; err_rgb = 0; vs_low = 0; fs_cnt = 0;
      for (int l = 0; l < 42; l++) begin
         for (int xv = 0; xv < 800; xv++) begin
            tick(10'(xv));
            exp_vs  = !(l == 38 || l == 39);
            exp_von = (xv < 640) && (l < 36);
            if (y != 10'(l)) err_y++;
            if (x != 10'(xv)) err_x++;
            if (hsync != !(xv >= 656 && xv < 752)) err_hs++;
            if (vsync != exp_vs) err_vs++;
            if (video_on != exp_von) err_von++;
            if (is_vertical_active != (l < 36)) err_va++;
            if (frame_start != (l == 0 && xv == 0)) err_fs++;
            if (rgb != (exp_von ? 8'hFF : 8'h00)) err_rgb++;
            if (!vsync) vs_low++;
            if (frame_start) fs_cnt++;
            if (l == 35 && xv == 639) begin
               check("align_von_639", 32'(video_on), 32'd1);
               check("align_rgb_639", 32'(rgb), 32'hFF);
            end
            if (l == 35 && xv == 640) begin
               check("align_von_640", 32'(video_on), 32'd0);
               check("align_rgb_640", 32'(rgb), 32'h00);
            end
            if (l == 36 && xv == 100) begin
               check("line36_von", 32'(video_on), 32'd0);
               check("line36_rgb", 32'(rgb), 32'h00);
            end
         end
      end
      check("frame_y_per_line", err_y, 0);
      check("frame_x_align", err_x, 0);
      check("frame_hsync_align", err_hs, 0);
      check("frame_vsync_lines", err_vs, 0);
      check("frame_vsync_low_cycles", vs_low, 1600);
      check("frame_video_on", err_von, 0);
      check("frame_vert_active", err_va, 0);
      check("frame_start_pos", err_fs, 0);
      check("frame_start_count", fs_cnt, 1);
      check("frame_rgb", err_rgb, 0);

      // Wrap 41 -> 0 and second frame start
      tick(10'd0);
      check("wrap_y0", 32'(y), 32'd0);
      check("wrap_frame_start", 32'(frame_start), 32'd1);
      check("wrap_frame_count", 32'(frame_count), 32'd1);

      // Pattern request mid-frame must wait for the frame boundary
      next_lines(5);
      pattern_sel = 2'd2;
      tick(10'd100);
      check("pat_hold_l5", 32'(rgb), 32'hFF);
      next_lines(30);
      tick(10'd100);
      check("pat_hold_l35", 32'(rgb), 32'hFF);
      next_lines(6);
      tick(10'd799);
      tick(10'd32);
      check("chk_32_0", 32'(rgb), 32'hFF);
      check("chk_fc2", 32'(frame_count), 32'd2);
      pattern_sel = 2'd1;
      next_lines(32);
      tick(10'd32);
      check("chk_32_32", 32'(rgb), 32'h00);
      check("chk_y32", 32'(y), 32'd32);
      tick(10'd0);
      check("chk_0_32", 32'(rgb), 32'hFF);

      // Vertical bars: x=384 -> bits[9:7]=011 -> 011_011_11
      next_lines(9);
      tick(10'd799);
      tick(10'd384);
      check("bars_384", 32'(rgb), 32'h6F);

      // Pattern 3 over 256 frames, covering the frame counter wrap
      pattern_sel = 2'd3;
      next_lines(41);
      tick(10'd799);
      err_rgb = 0;
      exp_fc  = 8'd4;
      for (int f = 4; f < 260; f++) begin
         tick(10'd10);
         if (rgb != exp_fc || frame_count != exp_fc) err_rgb++;
         if (f == 255) check("fc_255", 32'(frame_count), 32'd255);
         if (f == 256) check("fc_wrap_0", 32'(frame_count), 32'd0);
         for (int l = 0; l < 42; l++) tick(10'd799);
         exp_fc = exp_fc + 8'd1;
      end
      check("pat3_rgb_eq_fc", err_rgb, 0);

      // Reset mid-line 20; pattern_sel during reset is ignored
      tick(10'd10);
      for (int l = 0; l < 20; l++) tick(10'd799);
      tick(10'd300);
      check("pre_rst_y20", 32'(y), 32'd20);
      reset       = 1'b1;
      pattern_sel = 2'd2;
      tick(10'd301);
      check("midrst_y", 32'(y), 32'd0);
      check("midrst_x", 32'(x), 32'd0);
      check("midrst_fc", 32'(frame_count), 32'd0);
      check("midrst_rgb", 32'(rgb), 32'd0);
      reset = 1'b0;
      tick(10'd302);
      check("post_rst_y0", 32'(y), 32'd0);
      check("post_rst_pat0", 32'(rgb), 32'hFF);
      tick(10'd799);
      tick(10'd0);
      check("post_rst_y1", 32'(y), 32'd1);

      // Out-of-range x_in: no line end, counters hold
      tick(10'd1000);
      check("oor_x", 32'(x), 32'd1000);
      check("oor_von", 32'(video_on), 32'd0);
      tick(10'd1000);
      tick(10'd0);
      check("oor_y_hold", 32'(y), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
